// File: rtl/instr_fetch.sv
// instr_fetch: single-request instruction fetch FSM with next-PC select; IFETCH_MISALIGN_TRAP_EN traps misaligned targets.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_fault
);
  typedef enum logic [1:0] {IDLE, REQ, VALID, FAULT} state_t;
  state_t      r_state, w_next_state;
  logic [31:0] r_pc, r_instr;
  logic [31:0] w_seq, w_rel, w_jalr, w_raw_next, w_next_pc;
  logic        w_retire, w_misalign;
  assign w_seq      = r_pc + 32'd4;
  assign w_rel      = r_pc + imm;
  assign w_jalr     = (rs1_data + imm) & 32'hFFFF_FFFE;
  assign w_raw_next = pc_src == 2'b00 ? w_seq :
                      pc_src == 2'b01 ? (branch_taken ? w_rel : w_seq) :
                      pc_src == 2'b10 ? w_rel : w_jalr;
  assign w_retire   = r_state == VALID && !stall;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic r_fault;
  assign w_misalign  = |w_raw_next[1:0];
  assign w_next_pc   = w_raw_next;
  assign fetch_fault = r_fault;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_fault <= 1'b0;
    else if (w_retire && w_misalign) r_fault <= 1'b1;
`else
  assign w_misalign  = 1'b0;
  assign w_next_pc   = w_raw_next & 32'hFFFF_FFFC;
  assign fetch_fault = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next_state;
  always_comb begin
    w_next_state = r_state;
    imem_req     = 1'b0;
    instr_valid  = 1'b0;
    w_next_state = r_state == IDLE  ? REQ :
                   r_state == REQ   ? (imem_rvalid ? VALID : REQ) :
                   r_state == VALID ? (w_retire ? (w_misalign ? FAULT : REQ) : VALID) : FAULT;
    imem_req     = r_state == REQ;
    instr_valid  = r_state == VALID;
  end
  // instr is cleared back to NOP on retire so it reads NOP in every non-VALID state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
    end else if (r_state == REQ && imem_rvalid) begin
      r_instr <= imem_rdata;
    end else if (w_retire) begin
      r_instr <= NOP_INSTR;
      r_pc    <= w_next_pc;
    end
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign pc_plus4  = w_seq;
  assign instr     = r_instr;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed fetch sequences; a negedge monitor scores each new VALID instruction against a queue.
module tb_instr_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 0, rst_n = 0;
  logic [1:0]  pc_src = 0;
  logic        branch_taken = 0, stall = 1, imem_rvalid = 0;
  logic [31:0] imm = 0, rs1_data = 0, imem_rdata = 0;
  logic        imem_req, instr_valid, fetch_fault;
  logic [31:0] imem_addr, instr, pc, pc_plus4;
  logic [63:0] q[$];
  logic        prev_valid = 0;
  int          n_checks = 0, n_fail = 0;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .branch_taken(branch_taken),
    .imm(imm), .rs1_data(rs1_data), .stall(stall), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (instr_valid && !prev_valid) begin
      if (q.size() == 0) chk("unexpected_valid", pc, 32'hxxxx_xxxx);
      else begin
        logic [63:0] e;
        e = q.pop_front();
        chk("mon_instr", instr, e[63:32]);
        chk("mon_pc", pc, e[31:0]);
        chk("mon_req_low", {31'b0, imem_req}, 32'd0);
      end
    end
    prev_valid <= instr_valid;
  end

  task automatic serve(input logic [31:0] data, input logic [31:0] epc, input int dly);
    int n = 0;
    while (!imem_req && n < 20) begin @(posedge clk); #1; n++; end
    chk("req_seen", {31'b0, imem_req}, 32'd1);
    q.push_back({data, epc});
    for (int i = 0; i < dly; i++) begin
      chk("req_hold", {31'b0, imem_req}, 32'd1);
      chk("addr_hold", imem_addr, epc);
      @(posedge clk); #1;
    end
    chk("imem_addr", imem_addr, epc);
    imem_rvalid = 1; imem_rdata = data;
    @(posedge clk); #1;
    imem_rvalid = 0; imem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic retire(input logic [1:0] src, input logic bt, input logic [31:0] im, input logic [31:0] r1);
    pc_src = src; branch_taken = bt; imm = im; rs1_data = r1; stall = 0;
    @(posedge clk); #1;
    stall = 1; pc_src = 2'b11; branch_taken = 1; imm = 32'h5555_5555; rs1_data = 32'hAAAA_AAAA;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", pc, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    imem_rvalid = 1; imem_rdata = 32'hBAD0_0001;
    rst_n = 1;
    @(posedge clk); #1;
    imem_rvalid = 0;
    chk("idle_ignores_rvalid", instr, NOP);
    serve(32'h0050_0093, 32'h0, 0);
    retire(2'b00, 0, 32'h0, 32'h0);
    serve(32'h1111_1111, 32'h4, 0);
    retire(2'b01, 0, 32'h40, 32'h0);
    serve(32'h2222_2222, 32'h8, 0);
    chk("pc_plus4", pc_plus4, 32'd12);
    retire(2'b11, 0, 32'h0, 32'h100);
    serve(32'h3333_3333, 32'h100, 0);
    retire(2'b01, 1, 32'hFFFF_FFF0, 32'h0);
    serve(32'h4444_4444, 32'hF0, 0);
    retire(2'b11, 0, 32'hC, 32'hFFFF_FFF0);
    serve(32'h5555_5555, 32'hFFFF_FFFC, 0);
    retire(2'b00, 0, 32'h0, 32'h0);
    serve(32'h6666_6666, 32'h0, 0);
    retire(2'b11, 0, 32'h4, 32'h2001);
    serve(32'h7777_7777, 32'h2004, 0);
    for (int i = 0; i < 3; i++) begin
      imem_rvalid = 1; imem_rdata = 32'hBAD0_0002;
      @(posedge clk); #1;
      chk("stall_instr", instr, 32'h7777_7777);
      chk("stall_pc", pc, 32'h2004);
      chk("stall_req", {31'b0, imem_req}, 32'd0);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
    end
    imem_rvalid = 0;
    retire(2'b00, 0, 32'h0, 32'h0);
    chk("after_retire_instr", instr, NOP);
    serve(32'h8888_8888, 32'h2008, 3);
    retire(2'b00, 0, 32'h0, 32'h0);
    chk("mid_req_addr", imem_addr, 32'h200C);
    rst_n = 0;
    #1;
    chk("abort_pc", pc, 32'h0);
    chk("abort_req", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1; imem_rdata = 32'hBAD0_0003;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    imem_rvalid = 0;
    chk("late_rvalid_valid", {31'b0, instr_valid}, 32'd0);
    chk("late_rvalid_instr", instr, NOP);
    chk("late_rvalid_req", {31'b0, imem_req}, 32'd1);
    serve(32'h9999_9999, 32'h0, 0);
    retire(2'b10, 0, 32'h2, 32'h0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk("trap_pc", pc, 32'h2);
    for (int i = 0; i < 3; i++) begin
      chk("trap_fault", {31'b0, fetch_fault}, 32'd1);
      chk("trap_req", {31'b0, imem_req}, 32'd0);
      chk("trap_valid", {31'b0, instr_valid}, 32'd0);
      @(posedge clk); #1;
    end
`else
    chk("noalign_fault", {31'b0, fetch_fault}, 32'd0);
    serve(32'hAAAA_0001, 32'h0, 0);
    chk("noalign_fault_after", {31'b0, fetch_fault}, 32'd0);
`endif
    @(posedge clk); #1;
    chk("queue_empty", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
